// File: rtl/id_stage_pkg.sv
// Shared widths, opcode / EX-command / condition-code constants for the ID stage.
// Also holds the condition evaluator used by the decode logic.
package id_stage_pkg;

  localparam int WORD_WIDTH            = 32;
  localparam int REG_ADDR_W            = 4;
  localparam int REG_FILE_DEPTH        = 16;
  localparam int SIGNED_IMM_WIDTH      = 24;
  localparam int SHIFTER_OPERAND_WIDTH = 12;

  localparam logic [3:0] EX_NOP = 4'b0000;
  localparam logic [3:0] EX_MOV = 4'b0001;
  localparam logic [3:0] EX_MVN = 4'b1001;
  localparam logic [3:0] EX_ADD = 4'b0010;
  localparam logic [3:0] EX_ADC = 4'b0011;
  localparam logic [3:0] EX_SUB = 4'b0100;
  localparam logic [3:0] EX_SBC = 4'b0101;
  localparam logic [3:0] EX_AND = 4'b0110;
  localparam logic [3:0] EX_ORR = 4'b0111;
  localparam logic [3:0] EX_EOR = 4'b1000;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_MEM = 4'b0100;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
    CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
    CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
    CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
  } cond_e;

  // status = {N,Z,C,V}; the 1111 encoding never passes
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] status);
    logic n, z, c, v;
    {n, z, c, v} = status;
    case (cond_e'(cond))
      CC_EQ:   cond_check = z;
      CC_NE:   cond_check = ~z;
      CC_CS:   cond_check = c;
      CC_CC:   cond_check = ~c;
      CC_MI:   cond_check = n;
      CC_PL:   cond_check = ~n;
      CC_VS:   cond_check = v;
      CC_VC:   cond_check = ~v;
      CC_HI:   cond_check = c & ~z;
      CC_LS:   cond_check = ~c | z;
      CC_GE:   cond_check = (n == v);
      CC_LT:   cond_check = (n != v);
      CC_GT:   cond_check = ~z & (n == v);
      CC_LE:   cond_check = z | (n != v);
      CC_AL:   cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// 16x32 register file: sync write, sync reset (priority over write), two async read ports.
// WB_BYPASS_EN forwards a same-cycle write to the read ports.
module register_file
  import id_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [WORD_WIDTH-1:0] rd_data_a,
  output logic [WORD_WIDTH-1:0] rd_data_b
);

  logic [REG_FILE_DEPTH-1:0][WORD_WIDTH-1:0] regs;

  always_ff @(posedge clk) begin
    if (rst)        regs <= '0;
    else if (wr_en) regs[wr_addr] <= wr_data;
  end

`ifdef WB_BYPASS_EN
  assign rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
  assign rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
`else
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
`endif

endmodule

// File: rtl/id_stage.sv
// ARM-subset decode stage: register read, control decode, condition check and squash.
// Optional WB_BYPASS_EN macro enables write-to-read forwarding in the register file.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WORD_WIDTH-1:0]            pc_in,
  input  logic [WORD_WIDTH-1:0]            instruction_in,
  input  logic [3:0]                       status_reg,
  input  logic                             hazard,
  input  logic                             wb_en,
  input  logic [REG_ADDR_W-1:0]            wb_dst,
  input  logic [WORD_WIDTH-1:0]            wb_value,
  output logic [WORD_WIDTH-1:0]            pc_out,
  output logic [WORD_WIDTH-1:0]            instruction_out,
  output logic [REG_ADDR_W-1:0]            reg_file_dst,
  output logic [WORD_WIDTH-1:0]            val_Rn,
  output logic [WORD_WIDTH-1:0]            val_Rm,
  output logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate,
  output logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand,
  output logic [3:0]                       EX_command,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic                             WB_en,
  output logic                             Imm,
  output logic                             B,
  output logic                             SR_update,
  output logic [REG_ADDR_W-1:0]            src1,
  output logic [REG_ADDR_W-1:0]            src2,
  output logic                             two_src
);

  logic [3:0] cond, opcode;
  logic [1:0] mode;
  logic       i_bit, s_bit;

  assign cond   = instruction_in[31:28];
  assign mode   = instruction_in[27:26];
  assign i_bit  = instruction_in[25];
  assign opcode = instruction_in[24:21];
  assign s_bit  = instruction_in[20];

  logic [3:0] ex_cmd_d;
  logic       wb_en_d, mem_r_d, mem_w_d, b_d, sr_d, dp_ok;

  always_comb begin
    ex_cmd_d = EX_NOP;
    wb_en_d  = 1'b0;
    mem_r_d  = 1'b0;
    mem_w_d  = 1'b0;
    b_d      = 1'b0;
    sr_d     = 1'b0;
    dp_ok    = 1'b1;
    case (mode_e'(mode))
      MODE_DP: begin
        case (opcode)
          OP_MOV:  begin ex_cmd_d = EX_MOV; wb_en_d = 1'b1; end
          OP_MVN:  begin ex_cmd_d = EX_MVN; wb_en_d = 1'b1; end
          OP_ADD:  begin ex_cmd_d = EX_ADD; wb_en_d = 1'b1; end
          OP_ADC:  begin ex_cmd_d = EX_ADC; wb_en_d = 1'b1; end
          OP_SUB:  begin ex_cmd_d = EX_SUB; wb_en_d = 1'b1; end
          OP_SBC:  begin ex_cmd_d = EX_SBC; wb_en_d = 1'b1; end
          OP_AND:  begin ex_cmd_d = EX_AND; wb_en_d = 1'b1; end
          OP_ORR:  begin ex_cmd_d = EX_ORR; wb_en_d = 1'b1; end
          OP_EOR:  begin ex_cmd_d = EX_EOR; wb_en_d = 1'b1; end
          OP_CMP:  ex_cmd_d = EX_SUB;
          OP_TST:  ex_cmd_d = EX_AND;
          default: dp_ok = 1'b0;
        endcase
        sr_d = s_bit & dp_ok;
      end
      MODE_MEM: begin
        if (opcode == OP_MEM) begin
          ex_cmd_d = EX_ADD;
          mem_r_d  = s_bit;
          wb_en_d  = s_bit;
          mem_w_d  = ~s_bit;
        end
      end
      MODE_BR: b_d = 1'b1;
      default: ;
    endcase
  end

  logic squash;
  assign squash = hazard | ~cond_check(cond, status_reg);

  assign EX_command = squash ? EX_NOP : ex_cmd_d;
  assign WB_en      = wb_en_d & ~squash;
  assign mem_read   = mem_r_d & ~squash;
  assign mem_write  = mem_w_d & ~squash;
  assign B          = b_d     & ~squash;
  assign SR_update  = sr_d    & ~squash;
  assign Imm        = (mode == MODE_DP) & i_bit;

  // Operand selection uses the unsquashed decode so the hazard unit sees true sources.
  assign src1    = instruction_in[19:16];
  assign src2    = mem_w_d ? instruction_in[15:12] : instruction_in[3:0];
  assign two_src = ~i_bit | mem_w_d;

  assign pc_out           = pc_in;
  assign instruction_out  = instruction_in;
  assign reg_file_dst     = instruction_in[15:12];
  assign signed_immediate = instruction_in[23:0];
  assign shifter_operand  = instruction_in[11:0];

  register_file u_rf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wb_en),
    .wr_addr   (wb_dst),
    .wr_data   (wb_value),
    .rd_addr_a (src1),
    .rd_addr_b (src2),
    .rd_data_a (val_Rn),
    .rd_data_b (val_Rm)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expected values are hand-computed.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, instruction_in, wb_value;
  logic [3:0]  status_reg, wb_dst;
  logic        hazard, wb_en;
  logic [31:0] pc_out, instruction_out, val_Rn, val_Rm;
  logic [3:0]  reg_file_dst, EX_command, src1, src2;
  logic [23:0] signed_immediate;
  logic [11:0] shifter_operand;
  logic        mem_read, mem_write, WB_en, Imm, B, SR_update, two_src;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
    .status_reg(status_reg), .hazard(hazard), .wb_en(wb_en), .wb_dst(wb_dst),
    .wb_value(wb_value), .pc_out(pc_out), .instruction_out(instruction_out),
    .reg_file_dst(reg_file_dst), .val_Rn(val_Rn), .val_Rm(val_Rm),
    .signed_immediate(signed_immediate), .shifter_operand(shifter_operand),
    .EX_command(EX_command), .mem_read(mem_read), .mem_write(mem_write),
    .WB_en(WB_en), .Imm(Imm), .B(B), .SR_update(SR_update),
    .src1(src1), .src2(src2), .two_src(two_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // {EX, mem_read, mem_write, WB_en, B, SR_update}
  function automatic logic [8:0] ctl();
    return {EX_command, mem_read, mem_write, WB_en, B, SR_update};
  endfunction

  task automatic wb_write(input logic [3:0] dst, input logic [31:0] val);
    @(negedge clk);
    wb_en = 1'b1; wb_dst = dst; wb_value = val;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  task automatic apply(input logic [31:0] ins, input logic [3:0] st, input logic hz);
    @(negedge clk);
    instruction_in = ins; status_reg = st; hazard = hz;
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_in = 32'h0000_0104; instruction_in = 32'h0000_000E;
    status_reg = 4'b0000; hazard = 1'b0; wb_en = 1'b0; wb_dst = 4'd0; wb_value = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    // 1: reset state, Rn=R0, Rm=R14, EQ with Z=0 fails
    chk("rst_rn", val_Rn, 32'h0);
    chk("rst_rm", val_Rm, 32'h0);
    chk("rst_ctl", {23'h0, ctl()}, 32'h0);
    chk("pc_pass", pc_out, 32'h0000_0104);

    // 2: write R3, ADD R1,R3,R3 (AL)
    wb_write(4'd3, 32'h1234_5678);
    apply(32'hE083_1003, 4'b0000, 1'b0);
    chk("add_rn", val_Rn, 32'h1234_5678);
    chk("add_rm", val_Rm, 32'h1234_5678);
    chk("add_ctl", {23'h0, ctl()}, {23'h0, 4'b0010, 5'b00100});
    chk("add_dst", {28'h0, reg_file_dst}, 32'd1);
    chk("add_two_src", {31'h0, two_src}, 32'd1);

    // 3: CMP S=1 EQ, Z=1 passes; Z=0 squashes
    apply(32'h0151_0002, 4'b0100, 1'b0);
    chk("cmp_pass", {23'h0, ctl()}, {23'h0, 4'b0100, 5'b00001});
    apply(32'h0151_0002, 4'b0000, 1'b0);
    chk("cmp_fail", {23'h0, ctl()}, 32'h0);

    // 4: STR R2,[R5]; LDR with S=1 never updates SR
    apply(32'hE485_2000, 4'b0000, 1'b0);
    chk("str_src1", {28'h0, src1}, 32'd5);
    chk("str_src2", {28'h0, src2}, 32'd2);
    chk("str_two_src", {31'h0, two_src}, 32'd1);
    chk("str_ctl", {23'h0, ctl()}, {23'h0, 4'b0010, 5'b01000});
    apply(32'hE495_2000, 4'b0000, 1'b0);
    chk("ldr_ctl", {23'h0, ctl()}, {23'h0, 4'b0010, 5'b10100});
    chk("ldr_src2", {28'h0, src2}, 32'd0);

    // 5: AL branch, hazard squashes; data outputs still driven
    apply(32'hEA00_0010, 4'b0000, 1'b1);
    chk("br_hazard", {23'h0, ctl()}, 32'h0);
    chk("br_simm", {8'h0, signed_immediate}, 32'h0000_0010);
    apply(32'hEA00_0010, 4'b0000, 1'b0);
    chk("br_go", {23'h0, ctl()}, {23'h0, 4'b0000, 5'b00010});

    // extras: undefined opcode, cond 1111, GT pass, MOV immediate
    apply(32'hE060_0000, 4'b0000, 1'b0);
    chk("undef_op", {23'h0, ctl()}, 32'h0);
    apply(32'hF083_1003, 4'b1111, 1'b0);
    chk("cond_nv", {23'h0, ctl()}, 32'h0);
    apply(32'hC1A0_1000, 4'b1001, 1'b0);
    chk("mov_gt", {23'h0, ctl()}, {23'h0, 4'b0001, 5'b00100});
    apply(32'hC1A0_1000, 4'b1101, 1'b0);
    chk("mov_gt_z", {23'h0, ctl()}, 32'h0);
    apply(32'hE3A0_1005, 4'b0000, 1'b0);
    chk("movi_imm", {31'h0, Imm}, 32'd1);
    chk("movi_two_src", {31'h0, two_src}, 32'd0);
    chk("movi_shop", {20'h0, shifter_operand}, 32'h005);
    chk("movi_ctl", {23'h0, ctl()}, {23'h0, 4'b0001, 5'b00100});

    // 6: same-cycle write/read of R4
    wb_write(4'd4, 32'h0000_0011);
    apply(32'hE084_0000, 4'b0000, 1'b0);
    wb_en = 1'b1; wb_dst = 4'd4; wb_value = 32'h0000_00A5;
    #1;
`ifdef WB_BYPASS_EN
    chk("same_cycle_rn", val_Rn, 32'h0000_00A5);
`else
    chk("same_cycle_rn", val_Rn, 32'h0000_0011);
`endif
    @(negedge clk);
    wb_en = 1'b0;
    #1;
    chk("after_wr_rn", val_Rn, 32'h0000_00A5);

    // reset wins over a simultaneous write
    @(negedge clk);
    rst = 1'b1; wb_en = 1'b1; wb_dst = 4'd4; wb_value = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0; wb_en = 1'b0;
    #1;
    chk("rst_vs_wr", val_Rn, 32'h0);
    chk("rst_r3", {28'h0, src1}, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
